// File: rtl/inst_loader.sv
// Boot-time instruction loader: parses a length/payload/checksum byte frame, writes
// big-endian words to instruction memory and releases the processor on a good frame.
module inst_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_run,
    output logic        err,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(DEPTH);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  len_hi;
    logic [7:0]  csum;
    logic [1:0]  byte_cnt;
    logic [15:0] word_idx;
    logic [23:0] word_sr;
    logic        xfer;
    logic [15:0] len;
    logic        len_ok;
    logic        last_byte;

    assign in_ready = rst_n && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                                state_q == S_DATA   || state_q == S_CHK);
    assign xfer     = in_valid && in_ready;
    assign len      = {len_hi, in_data};
    assign len_ok   = (len != 16'd0) && ({1'b0, len} <= MAX_LEN);
    assign last_byte = (byte_cnt == 2'd3) && (word_idx == word_count - 16'd1);
    assign cpu_run  = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);

    // NOTE: every signal assigned in this block gets its default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: if (xfer) state_d = len_ok ? S_DATA : S_ERR;
            S_DATA:   if (xfer && last_byte) state_d = S_CHK;
            S_CHK:    if (xfer) state_d = (in_data == csum) ? S_DONE : S_ERR;
            S_DONE:   state_d = S_DONE;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_ERR;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_LEN_HI;
            len_hi     <= '0;
            csum       <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            word_sr    <= '0;
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q <= state_d;
            mem_we  <= 1'b0;
            case (state_q)
                S_LEN_HI: if (xfer) len_hi <= in_data;
                S_LEN_LO: begin
                    if (xfer && len_ok) begin
                        word_count <= len;
                        byte_cnt   <= '0;
                        word_idx   <= '0;
                        csum       <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sr  <= {word_sr[15:0], in_data};
                        // The 4th byte completes the word; the write is registered
                        // so the strobe lands one cycle after this transfer.
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {word_sr, in_data};
                            mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx  <= word_idx + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized frames,
// checked against a frame-level reference model of the expected writes and outcome.
module tb_inst_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct {
        int          edge_n;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        err;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    wr_t wr_q[$];

    inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe with the number of rising edges seen so far.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back('{cyc, mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t build_frame(input wq_t words, input bit corrupt);
        bq_t fb;
        logic [7:0] x = 8'h00;
        logic [15:0] n = 16'(words.size());
        fb.push_back(n[15:8]);
        fb.push_back(n[7:0]);
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                fb.push_back(words[i][b*8 +: 8]);
                x ^= words[i][b*8 +: 8];
            end
        end
        fb.push_back(corrupt ? ~x : x);
        return fb;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        check({tag, ".mem_addr"}, mem_addr, 32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".cpu_run"}, 32'(cpu_run), 32'd0);
        check({tag, ".err"}, 32'(err), 32'd0);
        check({tag, ".word_count"}, 32'(word_count), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".in_ready_in_reset"}, 32'(in_ready), 32'd0);
        check_reset_outputs(tag);
        rst_n = 1'b1;
    endtask

    // Send a frame and compare the result with what the frame rules predict.
    task automatic run_frame(input string tag, input bq_t fb, input int max_idle);
        int          n;
        bit          legal;
        bit          ok;
        logic [7:0]  x;
        wq_t         exp_words;
        int          exp_edge[$];
        int          first_edge = 0;
        int          last_edge = 0;
        int          mark;
        int          nbytes;
        n = int'({fb[0], fb[1]});
        legal = (n != 0) && (n <= DEPTH);
        x = 8'h00;
        if (legal) begin
            for (int w = 0; w < n; w++) begin
                exp_words.push_back({fb[2+4*w], fb[3+4*w], fb[4+4*w], fb[5+4*w]});
                for (int b = 0; b < 4; b++) x ^= fb[2+4*w+b];
            end
        end
        ok = legal && (fb[fb.size()-1] == x);
        nbytes = legal ? fb.size() : 2;
        mark = wr_q.size();
        for (int i = 0; i < nbytes; i++) begin
            if (i > 0) begin
                repeat ($urandom_range(max_idle)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data = 8'($urandom);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data = fb[i];
            if (!in_ready) begin
                errors++;
                checks++;
                $error("FAIL %s.in_ready byte %0d observed=0 expected=1", tag, i);
            end
            if (i == 0) first_edge = cyc + 1;
            if (i >= 2 && i < 2 + 4*n && ((i - 2) % 4) == 3) exp_edge.push_back(cyc + 1);
            if (i == nbytes - 1) begin
                last_edge = cyc + 1;
                check({tag, ".cpu_run_before_end"}, 32'(cpu_run), 32'd0);
                check({tag, ".err_before_end"}, 32'(err), 32'd0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
        check({tag, ".cpu_run"}, 32'(cpu_run), 32'(ok));
        check({tag, ".err"}, 32'(err), 32'(!ok));
        check({tag, ".in_ready_after"}, 32'(in_ready), 32'd0);
        check({tag, ".word_count"}, 32'(word_count), legal ? 32'(n) : 32'd0);
        if (max_idle == 0)
            check({tag, ".frame_time"}, 32'(last_edge - first_edge), legal ? 32'(4*n + 2) : 32'd1);
        repeat (2) @(negedge clk);
        check({tag, ".write_count"}, 32'(wr_q.size() - mark), 32'(exp_words.size()));
        for (int w = 0; w < exp_words.size() && mark + w < wr_q.size(); w++) begin
            check($sformatf("%s.addr%0d", tag, w), wr_q[mark+w].addr, BASE + 32'(4*w));
            check($sformatf("%s.data%0d", tag, w), wr_q[mark+w].data, exp_words[w]);
            check($sformatf("%s.strobe_edge%0d", tag, w), 32'(wr_q[mark+w].edge_n), 32'(exp_edge[w]));
        end
    endtask

    initial begin
        bq_t s1;
        bq_t fb;
        wq_t words;
        int  mark;
        s1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};

        // Power-up reset.
        repeat (2) @(negedge clk);
        check("por.in_ready", 32'(in_ready), 32'd0);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("por.in_ready_released", 32'(in_ready), 32'd1);

        // Valid frame at full rate, then post-done traffic.
        run_frame("full_rate", s1, 0);
        mark = wr_q.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 8'($urandom);
            check($sformatf("post_done.in_ready%0d", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_done.writes", 32'(wr_q.size() - mark), 32'd0);
        check("post_done.cpu_run", 32'(cpu_run), 32'd1);

        // Bad checksum.
        do_reset("rst_bad_chk");
        fb = s1;
        fb[10] = 8'h54;
        run_frame("bad_chk", fb, 0);

        // Illegal lengths: zero and DEPTH+1, followed by ignored traffic.
        do_reset("rst_len0");
        run_frame("len_zero", '{8'h00, 8'h00}, 0);
        do_reset("rst_len257");
        run_frame("len_257", '{8'h01, 8'h01}, 0);
        mark = wr_q.size();
        repeat (6) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("len_257.no_writes_later", 32'(wr_q.size() - mark), 32'd0);
        check("len_257.err_sticky", 32'(err), 32'd1);

        // Stalled source.
        do_reset("rst_stall");
        run_frame("stalled", s1, 3);

        // Reset after 6 bytes of the valid frame.
        do_reset("rst_mid");
        mark = wr_q.size();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = s1[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset.in_ready", 32'(in_ready), 32'd0);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_reset.writes", 32'(wr_q.size() - mark), 32'd1);
        check("mid_reset.state_len_hi", 32'(in_ready), 32'd1);
        run_frame("mid_reset_resend", s1, 0);

        // Randomized frames, including a full-depth one.
        for (int t = 0; t < 6; t++) begin
            words.delete();
            repeat ((t == 5) ? DEPTH : $urandom_range(8, 1)) words.push_back($urandom);
            do_reset($sformatf("rst_rand%0d", t));
            run_frame($sformatf("rand%0d", t), build_frame(words, $urandom_range(1) == 1),
                      (t == 5) ? 0 : int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time instruction loader sitting directly upstream of the single-cycle processor's instruction memory. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word-aligned byte addresses of the instruction memory. On a verified frame it releases the processor via `cpu_run`. This replaces preloading the instruction memory from a file in simulation.

## Interface

Parameters:
- `DEPTH`, 256: instruction memory capacity in words; maximum legal word count.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_ready`  out  1  loader can accept a byte; a byte transfers on a rising edge with `in_valid && in_ready`.
- `in_data`  in  8  stream byte.
- `mem_we`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  32  byte address of the write; word aligned.
- `mem_wdata`  out  32  instruction word to write.
- `cpu_run`  out  1  high once a frame is loaded and verified; the processor is held idle while low.
- `err`  out  1  frame rejected; sticky until reset.
- `word_count`  out  16  number of words declared by the accepted header.

## Operation

- Frame format: LEN_HI, LEN_LO (N = {LEN_HI, LEN_LO}), then 4·N payload bytes (MSB first per word), then one checksum byte equal to the XOR of all 4·N payload bytes. The header bytes are excluded from the checksum.
- States:
  - S_LEN_HI: on transfer, store the high length byte and go to S_LEN_LO.
  - S_LEN_LO: on transfer, form N.
    - N == 0 or N > DEPTH: go to S_ERR. No writes occur.
    - Otherwise: latch `word_count` = N, clear the byte counter, word index and checksum, and go to S_DATA.
  - S_DATA: on each transfer, shift the byte into the word register and XOR it into the checksum.
    - On the 4th byte of a word, issue a write and increment the word index.
    - After the byte that completes word N, go to S_CHK.
  - S_CHK: on transfer, go to S_DONE if the byte equals the checksum, else S_ERR.
  - S_DONE: `cpu_run`=1, `in_ready`=0. Terminal until reset.
  - S_ERR: `err`=1, `cpu_run`=0, `in_ready`=0. Terminal until reset.
- `in_ready` = 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CHK, and 0 otherwise. It is forced to 0 while `rst_n` is low.
- Write address: `mem_addr` = BASE_ADDR + 4·word_index (word_index = 0..N-1). Arithmetic is 32-bit and wraps modulo 2^32.
- A cycle with `in_valid`=0 changes nothing. `in_data` is ignored when there is no transfer.
- Words already written before an error or reset stay in memory. The loader never rewrites or erases them.

## Timing

- Reset values (the cycle after a rising edge with `rst_n`=0):
  - state S_LEN_HI
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `cpu_run`=0, `err`=0, `word_count`=0
  - internal counters and checksum cleared
- Reset mid-frame aborts immediately: no pending write is issued, and the next byte after reset is treated as LEN_HI.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered. The strobe is high for exactly one cycle, namely the cycle after the edge that transfers a word's 4th byte.
- Writes never stall the stream. At full rate (`in_valid` held high) one word is written every 4 cycles. The final word's strobe coincides with the first cycle in S_CHK.
- `cpu_run` and `err` rise the cycle after the checksum transfer.
  - Length-error case: `err` rises the cycle after the LEN_LO transfer.
- Minimum frame time: 4·N+3 cycles from the first transfer to `cpu_run` high.
- `word_count` is valid from the cycle after the LEN_LO transfer and holds until reset.

## Test plan

All scenarios use DEPTH=256 and BASE_ADDR=0.

- **Valid frame, full rate:** stream 00 02 20 08 00 05 01 09 50 20 55, `in_valid` held high.
  - Writes: addr 0x0 data 0x20080005, then addr 0x4 data 0x01095020, each a one-cycle strobe.
  - `word_count`=2; `cpu_run`=1 at cycle 12; `err`=0.
- **Bad checksum:** same stream with final byte 0x54.
  - Both writes still occur; `err`=1; `cpu_run` stays 0.
- **Illegal length:** headers 00 00, and separately 01 01 (257).
  - `err`=1 the cycle after the 2nd byte; `mem_we` never asserted; `in_ready`=0 afterwards.
- **Stalled source:** scenario 1 with 0–3 random idle `in_valid`=0 cycles between bytes.
  - Identical writes, `word_count` and `cpu_run` result; each strobe lands exactly one cycle after its 4th byte's transfer.
- **Reset mid-payload:** drop `rst_n` for one cycle after 6 bytes of scenario 1.
  - All outputs return to reset values; no write for the partial second word.
  - Resending the full frame loads addr 0 and 4 again and sets `cpu_run`=1.
- **Post-done traffic:** after scenario 1, drive `in_valid`=1 with arbitrary bytes for 10 cycles.
  - `in_ready`=0; no `mem_we`; `cpu_run` stays 1.
